// File: rtl/serial_compare_pkg.sv
// Shared types and defaults for the serial bit-pair comparator.
package serial_compare_pkg;

  localparam int unsigned FRAME_LEN_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/xnor2.sv
// Two-input XNOR gate used as the per-bit equality detector.
module xnor2 (
  input  logic A,
  input  logic B,
  output logic C
);

  assign C = ~(A ^ B);

endmodule

// File: rtl/serial_compare.sv
// Compares FRAME_LEN valid A/B bit pairs per frame and reports a saturating mismatch count.
// Optional abort input enabled by defining SERIAL_COMPARE_ABORT_EN.
module serial_compare
  import serial_compare_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             A,
  input  logic             B,
  input  logic             bit_valid,
`ifdef SERIAL_COMPARE_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned     IDX_W    = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] err_d;
  logic             busy_q;
  logic             done_q;
  logic             match_q;
  logic             eq_c;
  logic             abort_c;

  xnor2 u_xnor2 (
    .A (A),
    .B (B),
    .C (eq_c)
  );

`ifdef SERIAL_COMPARE_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Saturating mismatch increment for the current pair.
  always_comb begin
    err_d = err_q;
    if (!eq_c && (err_q != CNT_MAX)) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            idx_q   <= '0;
            err_q   <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (abort_c) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (bit_valid) begin
            err_q <= err_d;
            if (idx_q == LAST_IDX) begin
              // Last pair: result is final on this edge, done follows for one cycle.
              state_q <= DONE;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              match_q <= (err_d == '0);
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign match     = match_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_serial_compare.sv
// Self-checking bench for serial_compare: vector table, random frames vs. a counting model,
// and directed reset / saturation / single-bit-frame / abort sequences.
module tb_serial_compare;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0, a8 = 1'b0, b8 = 1'b0, v8 = 1'b0;
  logic       busy8, done8, match8;
  logic [3:0] err8;
`ifdef SERIAL_COMPARE_ABORT_EN
  logic       abort8 = 1'b0;
`endif

  logic       s1 = 1'b0, s255 = 1'b0, aw = 1'b0, bw = 1'b0, vw = 1'b0;
  logic       busy1, done1, match1;
  logic [0:0] err1;
  logic       busy255, done255, match255;
  logic [2:0] err255;

  int checks  = 0;
  int errors  = 0;
  int dones8  = 0;
  int dones1  = 0;
  int dones255 = 0;

  always #5 clk = ~clk;

  serial_compare #(.FRAME_LEN(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .bit_valid(v8),
`ifdef SERIAL_COMPARE_ABORT_EN
    .abort(abort8),
`endif
    .busy(busy8), .done(done8), .match(match8), .err_count(err8)
  );

  serial_compare #(.FRAME_LEN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .A(aw), .B(bw), .bit_valid(vw),
`ifdef SERIAL_COMPARE_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy1), .done(done1), .match(match1), .err_count(err1)
  );

  serial_compare #(.FRAME_LEN(255), .CNT_W(3)) u255 (
    .clk(clk), .rst_n(rst_n), .start(s255), .A(aw), .B(bw), .bit_valid(vw),
`ifdef SERIAL_COMPARE_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy255), .done(done255), .match(match255), .err_count(err255)
  );

  always @(posedge clk) begin
    if (done8)   dones8   <= dones8 + 1;
    if (done1)   dones1   <= dones1 + 1;
    if (done255) dones255 <= dones255 + 1;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         gap;
    bit         junk_on_start;
    int         exp_err;
    bit         exp_match;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gap < 0 selects a random 0..2 idle cycles before each valid pair.
  task automatic run_frame8(input logic [7:0] av, input logic [7:0] bv, input int gap,
                            input bit junk, input bit noise, input int exp_err,
                            input bit exp_match, input string tag);
    int d0;
    int g;
    d0 = dones8;
    start8 = 1'b1;
    if (junk) begin
      v8 = 1'b1; a8 = 1'b0; b8 = 1'b1;
    end
    step();
    start8 = 1'b0;
    v8 = 1'b0;
    check({tag, "_busy_run"}, 32'(busy8), 1);
    check({tag, "_err_start"}, 32'(err8), 0);
    for (int i = 0; i < 8; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) begin
        v8 = 1'b0;
        a8 = 1'($urandom);
        b8 = 1'($urandom);
        start8 = noise ? 1'($urandom) : 1'b0;
        step();
      end
      v8 = 1'b1;
      a8 = av[i];
      b8 = bv[i];
      start8 = noise ? 1'($urandom) : 1'b0;
      step();
    end
    v8 = 1'b0;
    start8 = noise;
    check({tag, "_done"}, 32'(done8), 1);
    check({tag, "_busy_done"}, 32'(busy8), 0);
    check({tag, "_err"}, 32'(err8), 32'(exp_err));
    check({tag, "_match"}, 32'(match8), 32'(exp_match));
    step();
    start8 = 1'b0;
    check({tag, "_done_clr"}, 32'(done8), 0);
    check({tag, "_idle_busy"}, 32'(busy8), 0);
    check({tag, "_done_count"}, 32'(dones8 - d0), 1);
    v8 = 1'b1; a8 = 1'b1; b8 = 1'b0;
    step();
    v8 = 1'b0;
    check({tag, "_err_hold"}, 32'(err8), 32'(exp_err));
    check({tag, "_match_hold"}, 32'(match8), 32'(exp_match));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] av;
    logic [7:0] bv;
    int d0;

    vecs[0] = '{a: 8'hFF, b: 8'hFF, gap: 0, junk_on_start: 1'b0, exp_err: 0, exp_match: 1'b1};
    vecs[1] = '{a: 8'hED, b: 8'hFF, gap: 3, junk_on_start: 1'b0, exp_err: 2, exp_match: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'hFF, gap: 1, junk_on_start: 1'b0, exp_err: 8, exp_match: 1'b0};
    vecs[3] = '{a: 8'hA5, b: 8'hA5, gap: 2, junk_on_start: 1'b1, exp_err: 0, exp_match: 1'b1};
    vecs[4] = '{a: 8'h0F, b: 8'hF0, gap: 0, junk_on_start: 1'b1, exp_err: 8, exp_match: 1'b0};
    vecs[5] = '{a: 8'h01, b: 8'h00, gap: 0, junk_on_start: 1'b0, exp_err: 1, exp_match: 1'b0};

    step();
    step();
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    check("rst_match", 32'(match8), 0);
    check("rst_err", 32'(err8), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_frame8(vecs[i].a, vecs[i].b, vecs[i].gap, vecs[i].junk_on_start, 1'b0,
                 vecs[i].exp_err, vecs[i].exp_match, $sformatf("vec%0d", i));
    end

    // Random frames with random gaps and stray start pulses; model is a popcount.
    for (int n = 0; n < 20; n++) begin
      av = 8'($urandom);
      bv = ($urandom_range(0, 3) == 0) ? av : 8'($urandom);
      run_frame8(av, bv, -1, 1'($urandom), 1'b1, $countones(av ^ bv), av == bv,
                 $sformatf("rand%0d", n));
    end

    // Reset after 4 of 8 bits, overriding a simultaneous start and valid pair.
    d0 = dones8;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v8 = 1'b1; a8 = 1'b1; b8 = 1'b0;
      step();
    end
    check("mid_err_before_rst", 32'(err8), 4);
    rst_n = 1'b0;
    start8 = 1'b1;
`ifdef SERIAL_COMPARE_ABORT_EN
    abort8 = 1'b1;
`endif
    step();
    rst_n = 1'b1;
    start8 = 1'b0;
    v8 = 1'b0;
`ifdef SERIAL_COMPARE_ABORT_EN
    abort8 = 1'b0;
`endif
    check("mid_rst_busy", 32'(busy8), 0);
    check("mid_rst_done", 32'(done8), 0);
    check("mid_rst_match", 32'(match8), 0);
    check("mid_rst_err", 32'(err8), 0);
    step();
    step();
    check("mid_rst_no_done", 32'(dones8 - d0), 0);
    check("mid_rst_idle", 32'(busy8), 0);
    run_frame8(8'h3C, 8'h3C, 0, 1'b0, 1'b0, 0, 1'b1, "after_rst");

    // 255 unequal pairs on a 3-bit counter: must stick at 7.
    d0 = dones255;
    s255 = 1'b1;
    step();
    s255 = 1'b0;
    for (int i = 0; i < 255; i++) begin
      vw = 1'b1; aw = 1'b1; bw = 1'b0;
      step();
      if (i == 7) check("sat_err_at8", 32'(err255), 7);
    end
    vw = 1'b0;
    check("sat_done", 32'(done255), 1);
    check("sat_err", 32'(err255), 7);
    check("sat_match", 32'(match255), 0);
    check("sat_busy", 32'(busy255), 0);
    step();
    check("sat_done_count", 32'(dones255 - d0), 1);

    // Single-pair frames.
    s1 = 1'b1;
    step();
    s1 = 1'b0;
    check("len1_busy", 32'(busy1), 1);
    vw = 1'b1; aw = 1'b0; bw = 1'b1;
    step();
    vw = 1'b0;
    check("len1_done", 32'(done1), 1);
    check("len1_err", 32'(err1), 1);
    check("len1_match", 32'(match1), 0);
    step();
    check("len1_done_clr", 32'(done1), 0);
    s1 = 1'b1;
    step();
    s1 = 1'b0;
    vw = 1'b1; aw = 1'b1; bw = 1'b1;
    step();
    vw = 1'b0;
    check("len1_eq_done", 32'(done1), 1);
    check("len1_eq_err", 32'(err1), 0);
    check("len1_eq_match", 32'(match1), 1);
    step();

`ifdef SERIAL_COMPARE_ABORT_EN
    d0 = dones8;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v8 = 1'b1; a8 = 1'b0; b8 = 1'b1;
      step();
    end
    v8 = 1'b0;
    abort8 = 1'b1;
    step();
    abort8 = 1'b0;
    check("abort_busy", 32'(busy8), 0);
    check("abort_err", 32'(err8), 0);
    check("abort_match", 32'(match8), 0);
    check("abort_done", 32'(done8), 0);
    step();
    check("abort_no_done", 32'(dones8 - d0), 0);
    // Abort together with start in IDLE has no effect on the start.
    start8 = 1'b1;
    abort8 = 1'b1;
    step();
    start8 = 1'b0;
    abort8 = 1'b0;
    check("abort_idle_start", 32'(busy8), 1);
    for (int i = 0; i < 8; i++) begin
      v8 = 1'b1; a8 = 1'b1; b8 = 1'b1;
      step();
    end
    v8 = 1'b0;
    check("abort_after_done", 32'(done8), 1);
    check("abort_after_match", 32'(match8), 1);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_compare.md
SERIAL_COMPARE -- requirements
Module: serial_compare

Interface
REQ-001 Parameter FRAME_LEN, default 8: number of valid bit pairs compared per frame, legal range 1..255.
REQ-002 Parameter CNT_W, default $clog2(FRAME_LEN+1): width of the mismatch counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port start  input  1  frame start request; sampled only in IDLE.
REQ-006 Port A  input  1  serial bit stream A.
REQ-007 Port B  input  1  serial bit stream B.
REQ-008 Port bit_valid  input  1  A/B pair valid this cycle.
REQ-009 Port busy  output  1  high while in RUN.
REQ-010 Port done  output  1  one-cycle pulse at frame end.
REQ-011 Port match  output  1  high when the last completed frame had zero mismatches.
REQ-012 Port err_count  output  CNT_W  mismatch count of the current or last frame.

Function
REQ-013 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-014 IDLE: start=1 -> RUN next cycle; err_count, bit index and match cleared to 0 on that edge.
REQ-015 IDLE: bit_valid ignored; err_count and match hold the last frame's result.
REQ-016 RUN: each cycle with bit_valid=1 counts one bit; per-bit equality = XNOR(A,B); XNOR=0 -> err_count+1.
REQ-017 RUN: bit_valid=0 -> no count, no index advance; any number of idle cycles allowed.
REQ-018 err_count saturates at 2^CNT_W-1; no wrap-around.
REQ-019 RUN: the FRAME_LEN-th valid bit -> DONE next cycle; err_count includes that bit on the same edge.
REQ-020 DONE: lasts exactly one cycle, done=1, match=(err_count==0), busy=0; then IDLE unconditionally.
REQ-021 Latency: the last valid bit is sampled at edge k; done=1 during cycle k..k+1.
REQ-022 start in RUN or DONE ignored; no restart or queuing.
REQ-023 start and bit_valid high in the same IDLE cycle -> that bit is not counted.
REQ-024 FRAME_LEN=1: a single valid bit in RUN -> DONE.

Reset
REQ-025 rst_n=0 at a clock edge: state IDLE, busy=0, done=0, match=0, err_count=0, bit index=0.
REQ-026 Reset mid-RUN discards the frame; no done pulse.
REQ-027 Reset overrides start, bit_valid and abort in the same cycle.

Configuration
REQ-028 Macro SERIAL_COMPARE_ABORT_EN defined: adds input port abort (1 bit).
REQ-029 With the macro, abort=1 in RUN -> IDLE next cycle, err_count=0, match=0, no done pulse.
REQ-030 With the macro, abort in IDLE or DONE is ignored.
REQ-031 Without the macro: the abort port is absent and the RUN state is left only via REQ-019 or reset.

Structure
REQ-032 Package serial_compare_pkg: state enum typedef (IDLE/RUN/DONE) and default FRAME_LEN constant.
REQ-033 Per-bit equality uses one instance of the existing xnor2 gate (A, B -> C); no other sub-module.

Verification
REQ-034 FRAME_LEN=8, start, 8 valid equal pairs (A=B=1) -> done pulse the cycle after the 8th bit, match=1, err_count=0.
REQ-035 FRAME_LEN=8, pairs A=0/B=1 on bits 2 and 5, others equal, bit_valid gaps of 3 cycles -> done once, match=0, err_count=2.
REQ-036 FRAME_LEN=255, CNT_W=3, all 255 pairs unequal -> err_count=7 (saturated), match=0.
REQ-037 rst_n=0 after 4 of 8 valid bits -> outputs all 0, no done; a new start then completes a normal frame.
REQ-038 start pulsed during RUN and during DONE -> ignored; one done per accepted start.
REQ-039 SERIAL_COMPARE_ABORT_EN defined: abort after 3 bits -> IDLE, err_count=0, no done; without the macro, the bench compiles without the abort port.
